multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have one clock and asynchronous active-high reset: clk input 1 (rising edge); rst input 1 (async, active-high).
REQ-002 SHALL have inputs: opcode input 6 (IR[31:26], stable from DECODE until next FETCH); mem_ready input 1 (memory access completes this cycle).
REQ-003 SHALL have 1-bit outputs PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst.
REQ-004 SHALL have 2-bit outputs ALUOp (00 add, 01 sub, 10 funct-decoded), ALUSrcB (00 reg B, 01 const 4, 10 sign-ext imm, 11 shifted imm) and PCSource (00 ALU, 01 ALUOut, 10 jump target).
REQ-005 SHALL have outputs state 4 (current state, debug), instr_done 1 (one-cycle retire pulse), illegal_op 1 (one-cycle pulse) and retired 32 (retired-instruction count).

Function
REQ-006 SHALL be a Moore FSM: control outputs decoded only from registered state, except mem_ready gating per REQ-009.
REQ-007 SHALL use states/encodings FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BEQ 8, JUMP 9, ADDIEX 10, ADDIWB 11; codes 12-15 SHALL go to FETCH next cycle.
REQ-008 SHALL drive per state (unlisted outputs 0): FETCH MemRead=1, IRWrite, PCWrite, ALUSrcB=01; DECODE ALUSrcB=11; MEMADR ALUSrcA=1, ALUSrcB=10; MEMRD MemRead, IorD; MEMWB RegWrite, MemtoReg; MEMWR MemWrite, IorD; EXEC ALUSrcA=1, ALUOp=10; RWB RegWrite, RegDst; BEQ ALUSrcA=1, ALUOp=01, PCWriteCond, PCSource=01; JUMP PCWrite, PCSource=10; ADDIEX ALUSrcA=1, ALUSrcB=10; ADDIWB RegWrite.
REQ-009 SHALL assert IRWrite and PCWrite in FETCH only when mem_ready=1; MemRead/MemWrite stay asserted while waiting.
REQ-010 SHALL hold FETCH, MEMRD and MEMWR while mem_ready=0 and advance on the edge where mem_ready=1.
REQ-011 SHALL transition: FETCH->DECODE; DECODE by opcode: 100011/101011->MEMADR, 000000->EXEC, 000100->BEQ, 000010->JUMP, 001000->ADDIEX, other->FETCH with illegal_op=1 that cycle.
REQ-012 SHALL transition MEMADR->MEMRD (100011) or MEMWR (101011); MEMRD->MEMWB; EXEC->RWB; ADDIEX->ADDIWB; MEMWB, MEMWR (when ready), RWB, ADDIWB, BEQ, JUMP->FETCH.
REQ-013 SHALL pulse instr_done for one cycle in each state transitioning to FETCH, excluding the illegal-opcode DECODE exit.
REQ-014 SHALL increment retired by 1 on each edge where instr_done=1, wrapping 0xFFFFFFFF->0.
REQ-015 SHALL give zero-wait cycle counts FETCH-to-FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-016 SHALL on rst=1 immediately set state=FETCH and retired=0, independent of clk.
REQ-017 SHALL while rst=1 drive FETCH outputs with IRWrite=PCWrite=0, instr_done=0 and illegal_op=0.
REQ-018 SHALL abandon any in-flight instruction on reset mid-operation; retired is not incremented for it.

Structure
REQ-019 SHALL take state encodings, opcode constants and ALUOp/ALUSrcB/PCSource codes from shared package mc_pkg, which the ALU-control decoder also uses for ALUOp.
REQ-020 SHALL place state-to-control decoding in one combinational sub-module mc_ctrl_decode; state register, next-state logic and counter stay in multicycle_control.

Verification
REQ-021 SHALL test: reset, mem_ready=1, opcode=100011 -> states 0,1,2,3,4,0; MemtoReg=1 and RegWrite=1 in state 4; retired=1.
REQ-022 SHALL test: opcode=101011, mem_ready=0 for 3 cycles in MEMWR -> MemWrite=1 held 4 cycles; instr_done once; retired+1.
REQ-023 SHALL test: opcode=000000 -> ALUOp=10 in EXEC, RegDst=1 and RegWrite=1 in RWB; opcode=000100 -> ALUOp=01, PCWriteCond=1, PCSource=01.
REQ-024 SHALL test: opcode=111111 -> illegal_op=1 in DECODE, then FETCH; retired unchanged.
REQ-025 SHALL test: rst asserted mid-MEMRD (no clk edge) -> state=0 immediately, retired=0; retired=0xFFFFFFFF plus j -> retired=0.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared state encodings, opcodes and datapath select codes for the multicycle controller
package mc_pkg;
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIMM = 2'b11;
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: Moore decode of the registered state into datapath control signals
module mc_ctrl_decode
    import mc_pkg::*;
(
    input  state_t     state,
    input  logic       fetch_ok,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource
);
    // per-state control table; fetch_ok gates the IR/PC update until memory returns data
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUOp       = ALUOP_ADD;
        ALUSrcB     = SRCB_REG;
        PCSource    = PCSRC_ALU;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = fetch_ok;
                PCWrite = fetch_ok;
                ALUSrcB = SRCB_FOUR;
            end
            S_DECODE: ALUSrcB = SRCB_SHIMM;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_ADDIWB: RegWrite = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS control FSM with retire pulse and retired-instruction counter
module multicycle_control
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        IRWrite,
    output logic        ALUSrcA,
    output logic        RegWrite,
    output logic        RegDst,
    output logic [1:0]  ALUOp,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic [3:0]  state,
    output logic        instr_done,
    output logic        illegal_op,
    output logic [31:0] retired
);
    state_t cur, nxt;
    logic   done, illegal;

    assign state      = cur;
    assign instr_done = done & ~rst;
    assign illegal_op = illegal & ~rst;

    mc_ctrl_decode u_decode (
        .state       (cur),
        .fetch_ok    (mem_ready & ~rst),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .IRWrite     (IRWrite),
        .ALUSrcA     (ALUSrcA),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .ALUOp       (ALUOp),
        .ALUSrcB     (ALUSrcB),
        .PCSource    (PCSource)
    );

    // state register; reset abandons whatever instruction is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur <= S_FETCH;
        else     cur <= nxt;
    end

    // next state, plus retire/illegal flags raised on the cycle that returns to FETCH
    always_comb begin
        nxt     = cur;
        done    = 1'b0;
        illegal = 1'b0;
        case (cur)
            S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_RTYPE:     nxt = S_EXEC;
                    OP_BEQ:       nxt = S_BEQ;
                    OP_J:         nxt = S_JUMP;
                    OP_ADDI:      nxt = S_ADDIEX;
                    default: begin
                        nxt     = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  nxt = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR: begin
                nxt  = mem_ready ? S_FETCH : S_MEMWR;
                done = mem_ready;
            end
            S_EXEC:   nxt = S_RWB;
            S_ADDIEX: nxt = S_ADDIWB;
            S_MEMWB, S_RWB, S_BEQ, S_JUMP, S_ADDIWB: begin
                nxt  = S_FETCH;
                done = 1'b1;
            end
            default:  nxt = S_FETCH;
        endcase
    end

    // retired-instruction counter, wraps naturally at 32 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             retired <= 32'd0;
        else if (instr_done) retired <= retired + 32'd1;
    end
endmodule
